// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 8-bit datapath: fetch, decode, execute,
// immediate and write-back sequencing, with the program counter and ALU flags.
module cpu_ctrl_fsm #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_data,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] pc,
  output logic [7:0] ir,
  output logic [2:0] alu_op,
  output logic [1:0] rd_addr_a,
  output logic [1:0] rd_addr_b,
  output logic       reg_we,
  output logic [1:0] reg_waddr,
  output logic       reg_wsel,
  output logic [7:0] imm,
  output logic       flag_z,
  output logic       flag_c,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_IMM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  state_t state;

  // 8-bit modulo increment; wrap from 8'hFF to 8'h00 is intentional.
  function automatic logic [7:0] pc_inc(input logic [7:0] cur);
    return cur + 8'd1;
  endfunction

  logic [2:0] opcode;
  assign opcode = ir[7:5];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      ir     <= 8'h00;
      imm    <= 8'h00;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir    <= mem_data;
          pc    <= pc_inc(pc);
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == OP_JMP && ir[4])
            state <= S_HALT;
          else if (opcode == OP_LDI || opcode == OP_JMP)
            state <= S_IMM;
          else
            state <= S_EXEC;
        end
        S_EXEC: begin
          flag_z <= alu_zero;
          flag_c <= alu_carry;
          state  <= S_WB;
        end
        S_IMM: begin
          if (opcode == OP_LDI) begin
            imm   <= mem_data;
            pc    <= pc_inc(pc);
            state <= S_WB;
          end else begin
            // JZ: operand byte is the target; a not-taken branch still skips it
            pc    <= flag_z ? mem_data : pc_inc(pc);
            state <= S_FETCH;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // ir is stable from DECODE through WB, so these stay valid for the ALU and regfile
  assign alu_op    = ir[7:5];
  assign rd_addr_a = ir[3:2];
  assign rd_addr_b = ir[1:0];
  assign reg_waddr = ir[3:2];
  assign reg_wsel  = (opcode == OP_LDI);
  assign reg_we    = (state == S_WB) && !rst;
  assign halted    = (state == S_HALT);

endmodule
